// File: rtl/toggle_cov_pkg.sv
// Shared types and helpers for the toggle coverage tracker.
package toggle_cov_pkg;

  // Controller states for the tracker.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    ACTIVE = 2'd2,
    CLEAR  = 2'd3
  } state_e;

  // Widest vector the popcount helper accepts; callers zero-pad into it.
  localparam int POP_MAX = 256;

  // Width needed to hold a count from 0 up to and including width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Number of set bits in a zero-padded vector.
  function automatic int popcount(input logic [POP_MAX-1:0] vec);
    int n;
    n = 0;
    for (int i = 0; i < POP_MAX; i++) begin
      n += int'(vec[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/toggle_bit_cell.sv
// One bit of toggle history: last value, rise/fall seen, and whether the
// full toggle has already been counted.
module toggle_bit_cell #(
  parameter bit ONCE = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic sample,
  input  logic detect,
  input  logic clear,
  input  logic sig_bit,
  output logic pulse,
  output logic newly_done
);

  logic prev_q, prev_d;
  logic rose_q, rose_d;
  logic fell_q, fell_d;
  logic done_q, done_d;
  logic pulse_q;
  logic riseNow, fallNow, blocked, roseAcc, fellAcc, complete;

  // Work out this cycle's edges and the resulting rise/fall/done history.
  always_comb begin
    riseNow  = detect & ~prev_q & sig_bit;
    fallNow  = detect & prev_q & ~sig_bit;
    blocked  = ONCE & done_q;
    roseAcc  = rose_q | riseNow;
    fellAcc  = fell_q | fallNow;
    complete = detect & ~blocked & roseAcc & fellAcc;

    prev_d = (sample | detect) ? sig_bit : prev_q;
    rose_d = rose_q;
    fell_d = fell_q;
    done_d = done_q;
    if (clear) begin
      rose_d = 1'b0;
      fell_d = 1'b0;
      done_d = 1'b0;
    end else if (detect && !blocked) begin
      if (complete && !ONCE) begin
        rose_d = 1'b0;
        fell_d = 1'b0;
      end else begin
        rose_d = roseAcc;
        fell_d = fellAcc;
      end
      if (complete) begin
        done_d = 1'b1;
      end
    end

    newly_done = complete & ~done_q;
  end

  // Register the history and the one-cycle completion pulse.
  always_ff @(posedge clock) begin
    if (!reset) begin
      prev_q  <= 1'b0;
      rose_q  <= 1'b0;
      fell_q  <= 1'b0;
      done_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      rose_q  <= rose_d;
      fell_q  <= fell_d;
      done_q  <= done_d;
      pulse_q <= complete;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/toggle_cover_tracker.sv
// Toggle detector in front of a coverage sink: per-bit full-toggle pulses,
// a running count of covered bits, and a clear/acknowledge handshake.
module toggle_cover_tracker
  import toggle_cov_pkg::*;
#(
  parameter  int WIDTH = 17,
  parameter  int ONCE  = 1,
  localparam int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] sig,
  input  logic             en,
  input  logic             clear_req,
  output logic             clear_ack,
  output logic [WIDTH-1:0] valid,
  output logic [CNT_W-1:0] covered_cnt,
  output logic             all_covered
);

  state_e             state_q, state_d;
  logic               armed_q;
  logic               ack_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               clearGo;
  logic               sampleStb, detectStb, clearStb;
  logic [WIDTH-1:0]   newlyDone;
  logic [POP_MAX-1:0] padded;

  // Decode the current state into per-bit strobes and pick the next state;
  // an accepted clear beats both enable and detection.
  always_comb begin
    clearGo   = clear_req & armed_q;
    state_d   = state_q;
    sampleStb = 1'b0;
    detectStb = 1'b0;
    clearStb  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clearGo)  state_d = CLEAR;
        else if (en)  state_d = PRIME;
      end
      PRIME: begin
        sampleStb = 1'b1;
        if (clearGo)  state_d = CLEAR;
        else if (!en) state_d = IDLE;
        else          state_d = ACTIVE;
      end
      ACTIVE: begin
        if (clearGo)  state_d = CLEAR;
        else if (!en) state_d = IDLE;
        else          detectStb = 1'b1;
      end
      CLEAR: begin
        clearStb = 1'b1;
        state_d  = en ? PRIME : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Add up the bits that completed their first toggle this cycle.
  always_comb begin
    padded             = '0;
    padded[WIDTH-1:0]  = newlyDone;
    if (clearStb) cnt_d = '0;
    else          cnt_d = cnt_q + CNT_W'(popcount(padded));
  end

  // Controller registers: state, clear re-arm, acknowledge pulse, counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      armed_q <= 1'b1;
      ack_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (clearGo)         armed_q <= 1'b0;
      else if (!clear_req) armed_q <= 1'b1;
      ack_q   <= clearStb;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    toggle_bit_cell #(
      .ONCE(ONCE != 0)
    ) u_cell (
      .clock     (clock),
      .reset     (reset),
      .sample    (sampleStb),
      .detect    (detectStb),
      .clear     (clearStb),
      .sig_bit   (sig[i]),
      .pulse     (valid[i]),
      .newly_done(newlyDone[i])
    );
  end

  assign clear_ack   = ack_q;
  assign covered_cnt = cnt_q;
  assign all_covered = (cnt_q == CNT_W'(WIDTH));

endmodule

// File: doc/toggle_cover_tracker.md
# toggle_cover_tracker

Per-signal toggle detector that feeds the per-width toggle coverage sinks. It samples a WIDTH-bit design signal every cycle and tracks rising and falling transitions per bit. It emits a one-cycle `valid` pulse for each bit whose full toggle (both 0→1 and 1→0 seen) has just completed. One instance sits in front of each coverage sink, with `valid` wired straight into the sink's `valid` vector. It also keeps a running count of fully toggled bits and supports a clear/re-arm handshake for per-testcase coverage reset.

## Interface
- `WIDTH`, default 17: bits of the monitored signal and of `valid`.
- `ONCE`, default 1: 1 means each bit reports once until cleared; 0 means a bit reports every completed rise+fall pair.
- `clock`, input, 1: clock.
- `reset`, input, 1: synchronous, active-low.
- `sig`, input, WIDTH: monitored design signal.
- `en`, input, 1: sampling enable; coverage collection is gated off when low.
- `clear_req`, input, 1: level request to wipe toggle history and count.
- `clear_ack`, output, 1: one-cycle pulse confirming the clear completed.
- `valid`, output, WIDTH: one-cycle pulse per bit on full-toggle completion; goes to the coverage sink.
- `covered_cnt`, output, CNT_W = clog2(WIDTH+1): number of bits with a full toggle since the last reset or clear.
- `all_covered`, output, 1: high when `covered_cnt == WIDTH`.

## Operation
- Per-bit state: `prev` (last sampled value), `rose`, `fell`, `done` (full toggle counted).
- FSM states are IDLE, PRIME, ACTIVE and CLEAR. Reset (`reset==0`) enters IDLE.
- **IDLE:**
  - `en==1` → PRIME.
  - `clear_req==1` → CLEAR (takes priority over `en`).
- **PRIME:**
  - Captures `sig` into `prev`. No transitions are detected this cycle.
  - Next state is ACTIVE.
  - `en==0` → IDLE. `clear_req` → CLEAR.
- **ACTIVE:** for each bit i:
  - `prev[i]==0 && sig[i]==1` sets `rose[i]`.
  - `prev[i]==1 && sig[i]==0` sets `fell[i]`.
  - `prev` ← `sig`.
  - When `rose|fell` first reaches both-set, `valid[i]` pulses.
  - If ONCE=1: `done[i]` sets, and later toggles on that bit are ignored until a clear.
  - If ONCE=0: `rose[i]` and `fell[i]` clear on the pulse and the bit re-arms. `done[i]` still sets on the first completion.
- **ACTIVE exits:**
  - `en==0` → IDLE. `prev` holds; `rose`, `fell` and `done` are retained.
  - Re-enable goes through PRIME, so no spurious toggle is detected across the gap.
- **CLEAR:**
  - One cycle. Zeroes `rose`, `fell`, `done` and `covered_cnt`.
  - `clear_ack` pulses the following cycle.
  - Then → PRIME if `en==1`, else IDLE.
  - `clear_req` held high does not re-trigger until it is seen low for at least one cycle.
- **Precedence:** `clear_req` in ACTIVE wins over detection. Transitions sampled in that cycle are discarded and `valid` is 0 the next cycle.
- **Counter:**
  - `covered_cnt` += popcount of bits that newly set `done` this cycle. Multiple bits in one cycle are summed.
  - Cannot exceed WIDTH, because `done` is sticky.
- **Edge case:** a bit that rose then fell is counted once, even if both transitions completed at the final sample before `en` dropped.

## Timing
- `sig` sampled at edge t completes a toggle → `valid[i]` high during cycle t+1, for exactly one cycle.
- `covered_cnt` and `all_covered` update in the same cycle as `valid`.
- `clear_req` sampled in ACTIVE at edge t:
  - CLEAR during t+1.
  - `clear_ack`, and counts read 0, in cycle t+2.
  - PRIME in t+2.
  - First possible `valid` in t+4.
- Reset values: `valid`=0, `clear_ack`=0, `covered_cnt`=0, `all_covered`=0, FSM=IDLE, all per-bit state 0.
- Reset asserted mid-operation takes effect at the next edge and overrides everything, including a pending `clear_ack`.

## Structure
- Package `toggle_cov_pkg`:
  - FSM state enum (IDLE, PRIME, ACTIVE, CLEAR).
  - `CNT_W` function `clog2(WIDTH+1)`.
  - Popcount function.
- Sub-module `toggle_bit_cell`:
  - Per-bit `prev`, `rose`, `fell`, `done`.
  - Inputs: `sample`, `detect`, `clear`, `ONCE`.
  - Outputs: pulse and `newly_done`.
  - Generated WIDTH times.
- The top level holds the FSM, counter and `clear_ack` logic.

## Test plan
- **Basic toggle:** reset, `en=1`, `sig`=0 then bit 3 goes 1, then 0 → `valid`=17'h00008 exactly one cycle after the falling sample; `covered_cnt`=1.
- **ONCE behaviour:**
  - With ONCE=1, toggle bit 3 twice more → no further `valid`; `covered_cnt` stays 1.
  - With ONCE=0 → one pulse per completed pair; `covered_cnt` stays 1.
- **Many bits at once:** all bits 0→1→0 simultaneously → `valid`=17'h1FFFF for one cycle; `covered_cnt`=17; `all_covered`=1.
- **Enable gap:** bit 0 rises, `en`=0, `sig[0]` falls, `en`=1 → no `valid` (PRIME re-baselines); then bit 0 goes 1→0 → `valid[0]` pulses.
- **Clear vs toggle:** `clear_req` in the same cycle a toggle completes → no `valid`; `clear_ack` two cycles later; `covered_cnt`=0; the bit must toggle fully again to report.
- **Reset mid-clear:** `reset`=0 during CLEAR → `clear_ack` never pulses; all outputs are 0 after the edge.
